// File: rtl/act_readout_seq_pkg.sv
// Shared definitions for the activation readout sequencer: FSM encoding,
// response field layout and traversal-order codes.
package act_readout_seq_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    // Layout of a read response word.
    localparam int unsigned IDX_MSB = 27;
    localparam int unsigned IDX_LSB = 16;
    localparam int unsigned IDX_W   = IDX_MSB - IDX_LSB + 1;
    localparam int unsigned VAL_W   = 16;

    localparam logic ORDER_PE_MAJOR  = 1'b0;
    localparam logic ORDER_ACT_MAJOR = 1'b1;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO; a pop and a push in the same cycle
// are legal even when full, and a pop while empty is ignored.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q;
    logic             pop_ok, push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign count_o = count_q;

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Mask the head when empty so the stream outputs read as zero.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/act_readout_seq.sv
// Drains a block of output activations from the accelerator read port with a
// credit-limited request stream, checks returned indices and buffers results.
module act_readout_seq
    import act_readout_seq_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned RDATA_W    = 32,
    parameter int unsigned PE_W       = 6,
    parameter int unsigned PE_LSB     = 10,
    parameter int unsigned ACT_W      = 6,
    parameter int unsigned NUM_PE     = 64,
    parameter int unsigned ACT_DEPTH  = 64,
    parameter int unsigned CNT_W      = 12,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [CNT_W-1:0]   act_no_i,
    input  logic               order_i,
    input  logic               abort_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic               read_en_o,
    input  logic               read_rdy_i,
    output logic [ADDR_W-1:0]  read_addr_o,
    output logic               read_data_rdy_o,
    input  logic               read_data_vld_i,
    input  logic [RDATA_W-1:0] read_data_i,
    output logic               out_vld_o,
    input  logic               out_rdy_i,
    output logic [CNT_W-1:0]   out_idx_o,
    output logic [VAL_W-1:0]   out_val_o
);

    localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned MAX_ACT = NUM_PE * ACT_DEPTH;
    localparam int unsigned EW      = CNT_W + VAL_W;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  received_q, received_d;
    logic [CNT_W-1:0]  act_no_q, act_no_d;
    logic              order_q, order_d;
    logic [PE_W-1:0]   pe_q, pe_d;
    logic [ACT_W-1:0]  act_q, act_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic              err_q, err_d;

    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic              unused_fifo_full;
    logic [EW-1:0]     fifo_wdata, fifo_rdata;
    logic [CNT_W-1:0]  resp_idx;
    logic [CW:0]       credit_used;
    logic              credit_ok;
    logic              req_fire, resp_fire;
    logic              start_ok, oversize;
    logic              unused_rdata;

    // ------------------------------------------------------------------
    // Response decode
    // ------------------------------------------------------------------
    if (CNT_W >= IDX_W) begin : g_idx_ext
        assign resp_idx = CNT_W'(read_data_i[IDX_MSB:IDX_LSB]);
    end else begin : g_idx_trunc
        assign resp_idx = read_data_i[IDX_LSB +: CNT_W];
    end

    assign unused_rdata = ^read_data_i[RDATA_W-1:IDX_MSB+1];
    assign fifo_wdata   = {resp_idx, read_data_i[VAL_W-1:0]};

    assign req_fire  = read_en_o && read_rdy_i;
    assign resp_fire = read_data_vld_i && read_data_rdy_o;

    // A new command waits until the previous results have been fully drained.
    assign start_ok = start_i && fifo_empty;
    assign oversize = 32'(act_no_i) > MAX_ACT;

    // Every in-flight read owns a FIFO slot, so responses can never overflow.
    assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign credit_ok   = credit_used < (CW+1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d = (act_no_i == '0 || oversize) ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (issued_q == act_no_q || abort_i) state_d = StDrain;
            end
            StDrain: begin
                if (outstanding_q == '0) state_d = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy_o          = (state_q == StIssue) || (state_q == StDrain);
        done_o          = (state_q == StDone);
        err_o           = err_q;
        read_en_o       = (state_q == StIssue) && (issued_q < act_no_q) && credit_ok;
        read_data_rdy_o = busy_o;
        read_addr_o                   = '0;
        read_addr_o[PE_LSB +: PE_W]   = pe_q;
        read_addr_o[ACT_W-1:0]        = act_q;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            issued_q      <= '0;
            received_q    <= '0;
            act_no_q      <= '0;
            order_q       <= ORDER_PE_MAJOR;
            pe_q          <= '0;
            act_q         <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            issued_q      <= issued_d;
            received_q    <= received_d;
            act_no_q      <= act_no_d;
            order_q       <= order_d;
            pe_q          <= pe_d;
            act_q         <= act_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        issued_d      = issued_q;
        received_d    = received_q;
        act_no_d      = act_no_q;
        order_d       = order_q;
        pe_d          = pe_q;
        act_d         = act_q;
        err_d         = err_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_fire);

        if (state_q == StIdle && start_ok) begin
            act_no_d   = act_no_i;
            order_d    = order_i;
            issued_d   = '0;
            received_d = '0;
            pe_d       = '0;
            act_d      = '0;
            err_d      = oversize;
        end

        if (req_fire) begin
            issued_d = issued_q + 1'b1;
            if (order_q == ORDER_PE_MAJOR) begin
                if (pe_q == PE_W'(NUM_PE - 1)) begin
                    pe_d  = '0;
                    act_d = (act_q == ACT_W'(ACT_DEPTH - 1)) ? '0 : act_q + 1'b1;
                end else begin
                    pe_d = pe_q + 1'b1;
                end
            end else begin
                if (act_q == ACT_W'(ACT_DEPTH - 1)) begin
                    act_d = '0;
                    pe_d  = (pe_q == PE_W'(NUM_PE - 1)) ? '0 : pe_q + 1'b1;
                end else begin
                    act_d = act_q + 1'b1;
                end
            end
        end

        if (resp_fire) begin
            received_d = received_q + 1'b1;
            if (resp_idx != received_q) err_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output buffer
    // ------------------------------------------------------------------
    sync_fifo_fwft #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (resp_fire),
        .wdata_i (fifo_wdata),
        .pop_i   (out_rdy_i),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .full_o  (unused_fifo_full),
        .count_o (fifo_count)
    );

    assign out_vld_o = !fifo_empty;
    assign out_idx_o = fifo_rdata[EW-1:VAL_W];
    assign out_val_o = fifo_rdata[VAL_W-1:0];

endmodule

// File: tb/tb_act_readout_seq.sv
// Directed and randomized bench for act_readout_seq with an accelerator model
// and an address/index reference derived from the traversal rules.
module tb_act_readout_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] act_no = '0;
    logic        order = 1'b0;
    logic        abort = 1'b0;
    logic        busy, done, err, read_en;
    logic        read_rdy = 1'b0;
    logic [15:0] read_addr;
    logic        read_data_rdy;
    logic        read_data_vld = 1'b0;
    logic [31:0] read_data = '0;
    logic        out_vld;
    logic        out_rdy = 1'b0;
    logic [11:0] out_idx;
    logic [15:0] out_val;

    // Second instance for the small-array oversize case.
    logic        s_start = 1'b0;
    logic [11:0] s_act_no = '0;
    logic        s_busy, s_done, s_err, s_read_en, s_read_data_rdy, s_out_vld;
    logic [15:0] s_read_addr;
    logic [11:0] s_out_idx;
    logic [15:0] s_out_val;

    always #5 clk = ~clk;

    act_readout_seq u_dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .start_i         (start),
        .act_no_i        (act_no),
        .order_i         (order),
        .abort_i         (abort),
        .busy_o          (busy),
        .done_o          (done),
        .err_o           (err),
        .read_en_o       (read_en),
        .read_rdy_i      (read_rdy),
        .read_addr_o     (read_addr),
        .read_data_rdy_o (read_data_rdy),
        .read_data_vld_i (read_data_vld),
        .read_data_i     (read_data),
        .out_vld_o       (out_vld),
        .out_rdy_i       (out_rdy),
        .out_idx_o       (out_idx),
        .out_val_o       (out_val)
    );

    act_readout_seq #(
        .NUM_PE    (8),
        .ACT_DEPTH (64)
    ) u_small (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .start_i         (s_start),
        .act_no_i        (s_act_no),
        .order_i         (1'b0),
        .abort_i         (1'b0),
        .busy_o          (s_busy),
        .done_o          (s_done),
        .err_o           (s_err),
        .read_en_o       (s_read_en),
        .read_rdy_i      (1'b1),
        .read_addr_o     (s_read_addr),
        .read_data_rdy_o (s_read_data_rdy),
        .read_data_vld_i (1'b0),
        .read_data_i     (32'h0),
        .out_vld_o       (s_out_vld),
        .out_rdy_i       (1'b1),
        .out_idx_o       (s_out_idx),
        .out_val_o       (s_out_val)
    );

    typedef struct {
        int          seq;
        int          due;
        logic [15:0] addr;
    } pend_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [15:0] req_log[$];
    pend_t       pend[$];
    logic [11:0] got_idx[$];
    logic [15:0] got_val[$];

    int rdy_pct = 100, sink_pct = 100, dly_min = 2, dly_max = 2;
    int corrupt_seq = -1;
    bit hold_rdy = 1'b0;
    int done_cnt, done_cyc, max_inflight, first_vld_cyc, first_resp_cyc, last_resp_cyc;
    int re_cnt, stable_bad;
    logic done_err;
    bit prev_wait;
    logic [15:0] prev_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_addr(input int k, input bit ord);
        int pe, a;
        if (!ord) begin
            pe = k % 64;
            a  = (k / 64) % 64;
        end else begin
            a  = k % 64;
            pe = (k / 64) % 64;
        end
        return 16'(pe * 1024 + a);
    endfunction

    // One clock of the environment: accelerator, stream sink and monitors.
    task automatic step();
        pend_t p;
        int    idx, inflight;
        @(negedge clk);
        cyc++;
        inflight = req_log.size() - got_idx.size();
        if (inflight > max_inflight) max_inflight = inflight;
        if (done) begin
            done_cnt++;
            done_err = err;
            done_cyc = cyc;
        end
        if (out_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (read_en) re_cnt++;
        if (prev_wait && !(read_en && read_addr == prev_addr)) stable_bad++;

        out_rdy = ($urandom_range(99) < sink_pct);
        if (out_vld && out_rdy) begin
            got_idx.push_back(out_idx);
            got_val.push_back(out_val);
        end

        read_rdy = !hold_rdy && ($urandom_range(99) < rdy_pct);
        if (read_en && read_rdy) begin
            p.seq  = req_log.size();
            p.due  = cyc + $urandom_range(dly_max, dly_min);
            p.addr = read_addr;
            pend.push_back(p);
            req_log.push_back(read_addr);
        end
        prev_wait = read_en && !read_rdy;
        prev_addr = read_addr;

        read_data_vld = 1'b0;
        read_data     = '0;
        if (pend.size() > 0 && read_data_rdy && pend[0].due <= cyc) begin
            p   = pend.pop_front();
            idx = (p.seq == corrupt_seq) ? 7 : p.seq;
            read_data     = {4'h0, 12'(idx), p.addr ^ 16'h5A5A};
            read_data_vld = 1'b1;
            if (first_resp_cyc < 0) first_resp_cyc = cyc;
            last_resp_cyc = cyc;
        end
    endtask

    task automatic new_run();
        req_log.delete();
        pend.delete();
        got_idx.delete();
        got_val.delete();
        done_cnt = 0;
        done_err = 1'b0;
        done_cyc = -1;
        max_inflight = 0;
        first_vld_cyc = -1;
        first_resp_cyc = -1;
        last_resp_cyc = -1;
        re_cnt = 0;
        stable_bad = 0;
        prev_wait = 1'b0;
    endtask

    task automatic do_start(input int n, input bit ord);
        act_no = 12'(n);
        order  = ord;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    task automatic finish_run(input string tag, input int budget);
        int n = 0;
        int saved = sink_pct;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        check({tag, "_done_seen"}, done_cnt, 1);
        sink_pct = 100;
        n = 0;
        while (out_vld && n < 50) begin
            step();
            n++;
        end
        step();
        sink_pct = saved;
    endtask

    task automatic verify(input int n, input bit ord, input string tag);
        logic [11:0] ei;
        logic [15:0] ea;
        check({tag, "_nreq"}, req_log.size(), n);
        check({tag, "_nbeat"}, got_idx.size(), n);
        for (int k = 0; k < n; k++) begin
            ea = model_addr(k, ord);
            ei = (k == corrupt_seq) ? 12'd7 : 12'(k);
            if (k < req_log.size()) check($sformatf("%s_addr%0d", tag, k), req_log[k], ea);
            if (k < got_idx.size()) begin
                check($sformatf("%s_idx%0d", tag, k), got_idx[k], ei);
                check($sformatf("%s_val%0d", tag, k), got_val[k], ea ^ 16'h5A5A);
            end
        end
    endtask

    initial begin
        int n, wait_n;
        bit ord;

        new_run();
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_read_en", read_en, 0);
        check("rst_rdata_rdy", read_data_rdy, 0);
        check("rst_out_vld", out_vld, 0);
        check("rst_read_addr", read_addr, 0);
        rst_n = 1'b1;
        step();

        // Base read
        new_run();
        do_start(5, 1'b0);
        check("base_first_read_en", read_en, 1);
        finish_run("base", 200);
        verify(5, 1'b0, "base");
        check("base_addr3", req_log[3], 16'h0C00);
        check("base_addr4", req_log[4], 16'h1000);
        check("base_err", done_err, 0);
        check("base_resp_to_vld", first_vld_cyc - first_resp_cyc, 1);
        check("base_resp_to_done", done_cyc - last_resp_cyc, 2);
        check("base_stable", stable_bad, 0);

        // Wrap in both orders
        new_run();
        do_start(66, 1'b0);
        finish_run("wrap0", 1000);
        verify(66, 1'b0, "wrap0");
        check("wrap0_r64", req_log[64], 16'h0001);
        check("wrap0_r65", req_log[65], 16'h0401);
        new_run();
        do_start(66, 1'b1);
        finish_run("wrap1", 1000);
        verify(66, 1'b1, "wrap1");
        check("wrap1_r64", req_log[64], 16'h0400);
        check("wrap1_r65", req_log[65], 16'h0401);

        // Backpressure
        new_run();
        sink_pct = 0;
        do_start(10, 1'b0);
        repeat (30) step();
        check("bp_nreq_stalled", req_log.size(), 4);
        check("bp_read_en_low", read_en, 0);
        sink_pct = 100;
        finish_run("bp", 500);
        verify(10, 1'b0, "bp");
        check("bp_inflight", max_inflight <= 4, 1);

        // Index mismatch on response 3
        new_run();
        corrupt_seq = 3;
        do_start(8, 1'b0);
        finish_run("mis", 500);
        verify(8, 1'b0, "mis");
        check("mis_err_done", done_err, 1);
        check("mis_err_sticky", err, 1);
        corrupt_seq = -1;

        // Randomized runs
        for (int it = 0; it < 6; it++) begin
            new_run();
            rdy_pct  = $urandom_range(100, 30);
            sink_pct = $urandom_range(100, 20);
            dly_min  = $urandom_range(2, 1);
            dly_max  = dly_min + $urandom_range(3);
            n        = $urandom_range(150, 1);
            ord      = $urandom_range(1);
            do_start(n, ord);
            if (it == 0) check("err_cleared_by_start", err, 0);
            finish_run($sformatf("rnd%0d", it), 5000);
            verify(n, ord, $sformatf("rnd%0d", it));
            check($sformatf("rnd%0d_err", it), done_err, 0);
            check($sformatf("rnd%0d_stable", it), stable_bad, 0);
            check($sformatf("rnd%0d_inflight", it), max_inflight <= 4, 1);
        end
        rdy_pct = 100;
        sink_pct = 100;
        dly_min = 2;
        dly_max = 2;

        // Abort after 8 acceptances
        new_run();
        do_start(100, 1'b0);
        wait_n = 0;
        while (req_log.size() < 8 && wait_n < 200) begin
            step();
            wait_n++;
        end
        check("abort_reach8", req_log.size() >= 8, 1);
        hold_rdy = 1'b1;
        abort = 1'b1;
        step();
        abort = 1'b0;
        hold_rdy = 1'b0;
        re_cnt = 0;
        finish_run("abort", 500);
        verify(8, 1'b0, "abort");
        check("abort_no_read_en", re_cnt, 0);
        check("abort_busy_low", busy, 0);

        // act_no == 0
        new_run();
        do_start(0, 1'b0);
        check("zero_done", done, 1);
        check("zero_err", err, 0);
        check("zero_busy", busy, 0);
        step();
        check("zero_done_pulse", done, 0);

        // Oversize on the 8x64 instance
        s_act_no = 12'd4095;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        check("ovr_done", s_done, 1);
        check("ovr_err", s_err, 1);
        check("ovr_read_en", s_read_en, 0);
        step();
        check("ovr_read_en2", s_read_en, 0);
        check("ovr_busy", s_busy, 0);
        s_act_no = 12'd512;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        check("max_busy", s_busy, 1);
        check("max_err", s_err, 0);

        // Reset during ISSUE with buffered results
        new_run();
        sink_pct = 0;
        do_start(50, 1'b0);
        repeat (6) step();
        check("prerst_busy", busy, 1);
        rst_n = 1'b0;
        step();
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_err", err, 0);
        check("mrst_read_en", read_en, 0);
        check("mrst_rdata_rdy", read_data_rdy, 0);
        check("mrst_out_vld", out_vld, 0);
        check("mrst_read_addr", read_addr, 0);
        check("mrst_out_idx", out_idx, 0);
        check("mrst_out_val", out_val, 0);
        check("mrst_small_busy", s_busy, 0);
        new_run();
        sink_pct = 100;
        rst_n = 1'b1;
        repeat (3) step();
        check("post_rst_idle", busy, 0);
        new_run();
        do_start(3, 1'b1);
        finish_run("post", 200);
        verify(3, 1'b1, "post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
